// File: rtl/sprite_compositor_pipe.sv
// Sprite compositor pipeline: draws NUM_LAYERS rectangular sprite layers over a
// banded background, issues per-layer sprite ROM addresses and hides the ROM
// read latency behind a matching delay line. Latency is ROM_LAT+2 cycles.
module sprite_compositor_pipe #(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned COORD_W    = 11,
    parameter int unsigned PIX_W      = 12,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned ROM_LAT    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid_in,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             draw_x,
    input  logic [COORD_W-1:0]             draw_y,
    input  logic [1:0]                     bg_mode,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_y,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_w,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_h,
    input  logic [NUM_LAYERS*PIX_W-1:0]    layer_key,
    input  logic [NUM_LAYERS-1:0]          layer_key_en,
    output logic [NUM_LAYERS*ADDR_W-1:0]   rom_addr,
    input  logic [NUM_LAYERS*PIX_W-1:0]    rom_data,
    output logic [3:0]                     r,
    output logic [3:0]                     g,
    output logic [3:0]                     b,
    output logic                           pix_valid_out,
    output logic                           hsync_out,
    output logic                           vsync_out
);

    localparam int unsigned SUM_W       = COORD_W + 1;
    localparam int unsigned PROD_W      = 2 * COORD_W;
    localparam int unsigned BORDER_LO   = 10;
    localparam int unsigned BORDER_X_HI = 1268;
    localparam int unsigned BORDER_Y_HI = 789;
    localparam int unsigned GROUND_Y    = 670;
    localparam int unsigned GRASS_Y     = 609;

    localparam logic [PIX_W-1:0] COL_BORDER = PIX_W'(12'hF00);
    localparam logic [PIX_W-1:0] COL_GROUND = PIX_W'(12'h960);
    localparam logic [PIX_W-1:0] COL_GRASS  = PIX_W'(12'h9C0);
    localparam logic [PIX_W-1:0] COL_WIN    = PIX_W'(12'hCF0);
    localparam logic [PIX_W-1:0] COL_LOSE   = PIX_W'(12'hC0A);
    localparam logic [PIX_W-1:0] COL_SKY    = PIX_W'(12'h0AE);

    // Shadow copies of the layer parameters, refreshed only on frame_tick
    logic [NUM_LAYERS-1:0]         sh_en;
    logic [NUM_LAYERS-1:0]         sh_key_en;
    logic [NUM_LAYERS*COORD_W-1:0] sh_x;
    logic [NUM_LAYERS*COORD_W-1:0] sh_y;
    logic [NUM_LAYERS*COORD_W-1:0] sh_w;
    logic [NUM_LAYERS*COORD_W-1:0] sh_h;
    logic [NUM_LAYERS*PIX_W-1:0]   sh_key;

    // Parameters in force for the current pixel (the tick pixel already sees new values)
    logic [NUM_LAYERS-1:0]         eff_en_c;
    logic [NUM_LAYERS-1:0]         eff_key_en_c;
    logic [NUM_LAYERS*COORD_W-1:0] eff_x_c;
    logic [NUM_LAYERS*COORD_W-1:0] eff_y_c;
    logic [NUM_LAYERS*COORD_W-1:0] eff_w_c;
    logic [NUM_LAYERS*COORD_W-1:0] eff_h_c;
    logic [NUM_LAYERS*PIX_W-1:0]   eff_key_c;

    logic [NUM_LAYERS-1:0]         hit_c;
    logic [NUM_LAYERS*ADDR_W-1:0]  addr_c;
    logic [PIX_W-1:0]              bg_c;

    // S0 registers
    logic [NUM_LAYERS-1:0]         s0_hit;
    logic [NUM_LAYERS-1:0]         s0_key_en;
    logic [NUM_LAYERS*PIX_W-1:0]   s0_key;
    logic [PIX_W-1:0]              s0_bg;
    logic                          s0_valid;
    logic                          s0_hs;
    logic                          s0_vs;

    // Delay line matching the ROM read latency
    logic [NUM_LAYERS-1:0]         d_hit    [ROM_LAT];
    logic [NUM_LAYERS-1:0]         d_key_en [ROM_LAT];
    logic [NUM_LAYERS*PIX_W-1:0]   d_key    [ROM_LAT];
    logic [PIX_W-1:0]              d_bg     [ROM_LAT];
    logic                          d_valid  [ROM_LAT];
    logic                          d_hs     [ROM_LAT];
    logic                          d_vs     [ROM_LAT];

    logic [PIX_W-1:0]              col_c;

    // Capture shadow layer parameters at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en     <= '0;
            sh_key_en <= '0;
            sh_x      <= '0;
            sh_y      <= '0;
            sh_w      <= '0;
            sh_h      <= '0;
            sh_key    <= '0;
        end else if (frame_tick) begin
            sh_en     <= layer_en;
            sh_key_en <= layer_key_en;
            sh_x      <= layer_x;
            sh_y      <= layer_y;
            sh_w      <= layer_w;
            sh_h      <= layer_h;
            sh_key    <= layer_key;
        end
    end

    assign eff_en_c     = frame_tick ? layer_en     : sh_en;
    assign eff_key_en_c = frame_tick ? layer_key_en : sh_key_en;
    assign eff_x_c      = frame_tick ? layer_x      : sh_x;
    assign eff_y_c      = frame_tick ? layer_y      : sh_y;
    assign eff_w_c      = frame_tick ? layer_w      : sh_w;
    assign eff_h_c      = frame_tick ? layer_h      : sh_h;
    assign eff_key_c    = frame_tick ? layer_key    : sh_key;

    // Per-layer hit test and sprite address; rectangle ends use one extra bit so they never wrap
    for (genvar gi = 0; gi < int'(NUM_LAYERS); gi++) begin : g_layer
        logic [COORD_W-1:0] lx, ly, lw, lh, dx, dy;
        logic [SUM_W-1:0]   x_end, y_end;
        logic [PROD_W-1:0]  offs;
        logic               in_x, in_y;

        assign lx    = eff_x_c[gi*COORD_W +: COORD_W];
        assign ly    = eff_y_c[gi*COORD_W +: COORD_W];
        assign lw    = eff_w_c[gi*COORD_W +: COORD_W];
        assign lh    = eff_h_c[gi*COORD_W +: COORD_W];
        assign x_end = SUM_W'(lx) + SUM_W'(lw);
        assign y_end = SUM_W'(ly) + SUM_W'(lh);
        assign in_x  = (draw_x >= lx) && (SUM_W'(draw_x) < x_end);
        assign in_y  = (draw_y >= ly) && (SUM_W'(draw_y) < y_end);
        assign dx    = draw_x - lx;
        assign dy    = draw_y - ly;
        assign offs  = PROD_W'(dy) * PROD_W'(lw) + PROD_W'(dx);

        assign hit_c[gi] = eff_en_c[gi] && in_x && in_y;
        assign addr_c[gi*ADDR_W +: ADDR_W] = (hit_c[gi] && pix_valid_in) ? ADDR_W'(offs) : '0;
    end

    // Background colour: border, then ground/grass bands, then mode-selected sky
    always_comb begin
        bg_c = COL_SKY;
        if ((draw_x < COORD_W'(BORDER_LO)) || (draw_y < COORD_W'(BORDER_LO)) ||
            (draw_x >= COORD_W'(BORDER_X_HI)) || (draw_y >= COORD_W'(BORDER_Y_HI))) begin
            bg_c = COL_BORDER;
        end else if (draw_y > COORD_W'(GROUND_Y)) begin
            bg_c = COL_GROUND;
        end else if (draw_y > COORD_W'(GRASS_Y)) begin
            bg_c = COL_GRASS;
        end else begin
            case (bg_mode)
                2'd1:    bg_c = COL_WIN;
                2'd2:    bg_c = COL_LOSE;
                default: bg_c = COL_SKY;
            endcase
        end
    end

    // S0: register hit flags, ROM addresses, background and pixel flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_hit    <= '0;
            s0_key_en <= '0;
            s0_key    <= '0;
            s0_bg     <= '0;
            s0_valid  <= 1'b0;
            s0_hs     <= 1'b0;
            s0_vs     <= 1'b0;
            rom_addr  <= '0;
        end else begin
            s0_hit    <= hit_c;
            s0_key_en <= eff_key_en_c;
            s0_key    <= eff_key_c;
            s0_bg     <= bg_c;
            s0_valid  <= pix_valid_in;
            s0_hs     <= hsync_in;
            s0_vs     <= vsync_in;
            rom_addr  <= addr_c;
        end
    end

    // Carry S0 results ROM_LAT cycles so they meet the matching rom_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(ROM_LAT); k++) begin
                d_hit[k]    <= '0;
                d_key_en[k] <= '0;
                d_key[k]    <= '0;
                d_bg[k]     <= '0;
                d_valid[k]  <= 1'b0;
                d_hs[k]     <= 1'b0;
                d_vs[k]     <= 1'b0;
            end
        end else begin
            d_hit[0]    <= s0_hit;
            d_key_en[0] <= s0_key_en;
            d_key[0]    <= s0_key;
            d_bg[0]     <= s0_bg;
            d_valid[0]  <= s0_valid;
            d_hs[0]     <= s0_hs;
            d_vs[0]     <= s0_vs;
            for (int k = 1; k < int'(ROM_LAT); k++) begin
                d_hit[k]    <= d_hit[k-1];
                d_key_en[k] <= d_key_en[k-1];
                d_key[k]    <= d_key[k-1];
                d_bg[k]     <= d_bg[k-1];
                d_valid[k]  <= d_valid[k-1];
                d_hs[k]     <= d_hs[k-1];
                d_vs[k]     <= d_vs[k-1];
            end
        end
    end

    // Layer scan: the highest-index opaque hit wins; blanked pixels are black
    always_comb begin
        col_c = d_bg[ROM_LAT-1];
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (d_hit[ROM_LAT-1][i] &&
                !(d_key_en[ROM_LAT-1][i] &&
                  (rom_data[i*PIX_W +: PIX_W] == d_key[ROM_LAT-1][i*PIX_W +: PIX_W]))) begin
                col_c = rom_data[i*PIX_W +: PIX_W];
            end
        end
        if (!d_valid[ROM_LAT-1]) begin
            col_c = '0;
        end
    end

    // S_C: registered colour and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r             <= '0;
            g             <= '0;
            b             <= '0;
            pix_valid_out <= 1'b0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
        end else begin
            r             <= col_c[PIX_W-1 -: 4];
            g             <= col_c[PIX_W-5 -: 4];
            b             <= col_c[PIX_W-9 -: 4];
            pix_valid_out <= d_valid[ROM_LAT-1];
            hsync_out     <= d_hs[ROM_LAT-1];
            vsync_out     <= d_vs[ROM_LAT-1];
        end
    end

endmodule

// File: tb/tb_sprite_compositor_pipe.sv
// Bench for sprite_compositor_pipe: directed scenarios plus randomized frames,
// compared every cycle against a pixel-level reference model.
module tb_sprite_compositor_pipe;

    localparam int NL   = 8;
    localparam int CW   = 11;
    localparam int PW   = 12;
    localparam int AW   = 14;
    localparam int RL   = 2;
    localparam int LAT  = RL + 2;
    localparam int HIST = 8192;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_valid_in, hsync_in, vsync_in, frame_tick;
    logic [CW-1:0]     draw_x, draw_y;
    logic [1:0]        bg_mode;
    logic [NL-1:0]     layer_en, layer_key_en;
    logic [NL*CW-1:0]  layer_x, layer_y, layer_w, layer_h;
    logic [NL*PW-1:0]  layer_key;
    logic [NL*AW-1:0]  rom_addr;
    logic [NL*PW-1:0]  rom_data;
    logic [3:0]        r, g, b;
    logic              pix_valid_out, hsync_out, vsync_out;

    sprite_compositor_pipe #(
        .NUM_LAYERS(NL), .COORD_W(CW), .PIX_W(PW), .ADDR_W(AW), .ROM_LAT(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid_in(pix_valid_in), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .frame_tick(frame_tick), .draw_x(draw_x), .draw_y(draw_y),
        .bg_mode(bg_mode), .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y),
        .layer_w(layer_w), .layer_h(layer_h), .layer_key(layer_key),
        .layer_key_en(layer_key_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .r(r), .g(g), .b(b), .pix_valid_out(pix_valid_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // Sprite ROM model: contents derived from layer/address, optionally forced per layer
    logic              force_en  [NL];
    logic [PW-1:0]     force_val [NL];
    logic [NL*PW-1:0]  rom_q     [RL];

    function automatic logic [PW-1:0] rom_word(input int i, input logic [AW-1:0] a);
        if (force_en[i]) return force_val[i];
        return {4'(i), a[3:0], a[7:4]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++)
            rom_q[0][i*PW +: PW] <= rom_word(i, rom_addr[i*AW +: AW]);
        for (int k = 1; k < RL; k++)
            rom_q[k] <= rom_q[k-1];
    end
    assign rom_data = rom_q[RL-1];

    // Reference model state
    int s_en [NL], s_x [NL], s_y [NL], s_w [NL], s_h [NL], s_key [NL], s_ken [NL];
    logic [PW-1:0]    h_rgb  [HIST];
    logic [2:0]       h_flg  [HIST];
    logic [NL*AW-1:0] h_addr [HIST];
    int m;
    int vectors;
    int errors;

    function automatic logic [PW-1:0] model_bg(input int x, input int y, input int mode);
        if (x < 10 || y < 10 || x >= 1268 || y >= 789) return 12'hF00;
        if (y > 670) return 12'h960;
        if (y > 609) return 12'h9C0;
        if (mode == 1) return 12'hCF0;
        if (mode == 2) return 12'hC0A;
        return 12'h0AE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            s_en[i] = 0; s_x[i] = 0; s_y[i] = 0; s_w[i] = 0;
            s_h[i] = 0; s_key[i] = 0; s_ken[i] = 0;
        end
    endtask

    task automatic expect_val(input string tag, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic set_layer(input int i, input bit en, input int x, input int y, input int w,
                             input int h, input int key, input bit ken);
        layer_en[i]                = en;
        layer_x[i*CW +: CW]        = CW'(x);
        layer_y[i*CW +: CW]        = CW'(y);
        layer_w[i*CW +: CW]        = CW'(w);
        layer_h[i*CW +: CW]        = CW'(h);
        layer_key[i*PW +: PW]      = PW'(key);
        layer_key_en[i]            = ken;
    endtask

    // One pixel clock: check the outputs of this cycle, drive the next pixel, record its expectation
    task automatic pix(input int x, input int y, input bit v, input bit tick, input int mode);
        logic [PW-1:0]    er, col, d;
        logic [2:0]       ef;
        logic [NL*AW-1:0] ea, addr_all;
        int               a;
        bit               hit, hs, vs;
        er = (m >= LAT) ? h_rgb[m-LAT] : '0;
        ef = (m >= LAT) ? h_flg[m-LAT] : '0;
        ea = (m >= 1)   ? h_addr[m-1]  : '0;
        expect_val("rgb", 128'({r, g, b}), 128'(er));
        expect_val("flags", 128'({pix_valid_out, hsync_out, vsync_out}), 128'(ef));
        expect_val("rom_addr", 128'(rom_addr), 128'(ea));

        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        draw_x = CW'(x); draw_y = CW'(y); pix_valid_in = v; frame_tick = tick;
        hsync_in = hs; vsync_in = vs; bg_mode = 2'(mode);
        if (tick) begin
            for (int i = 0; i < NL; i++) begin
                s_en[i]  = int'(layer_en[i]);
                s_x[i]   = int'(layer_x[i*CW +: CW]);
                s_y[i]   = int'(layer_y[i*CW +: CW]);
                s_w[i]   = int'(layer_w[i*CW +: CW]);
                s_h[i]   = int'(layer_h[i*CW +: CW]);
                s_key[i] = int'(layer_key[i*PW +: PW]);
                s_ken[i] = int'(layer_key_en[i]);
            end
        end
        col = model_bg(x, y, mode);
        addr_all = '0;
        for (int i = 0; i < NL; i++) begin
            hit = (s_en[i] != 0) && x >= s_x[i] && x < s_x[i] + s_w[i] &&
                  y >= s_y[i] && y < s_y[i] + s_h[i];
            a = (hit && v) ? ((y - s_y[i]) * s_w[i] + (x - s_x[i])) : 0;
            addr_all[i*AW +: AW] = AW'(a);
            if (hit) begin
                d = rom_word(i, AW'(a));
                if (!(s_ken[i] != 0 && int'(d) == s_key[i])) col = d;
            end
        end
        if (!v) col = '0;
        h_rgb[m] = col; h_flg[m] = {v, hs, vs}; h_addr[m] = addr_all;
        @(posedge clk); #1;
        m++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) pix(0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic random_layers();
        for (int i = 0; i < NL; i++)
            set_layer(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 300)),
                      int'($urandom_range(0, 300)), int'($urandom_range(0, 150)),
                      int'($urandom_range(0, 150)),
                      int'({4'(i), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))}),
                      1'($urandom_range(0, 1)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vectors = 0; errors = 0; m = 0;
        rst_n = 1'b0;
        pix_valid_in = 0; hsync_in = 0; vsync_in = 0; frame_tick = 0;
        draw_x = '0; draw_y = '0; bg_mode = '0;
        layer_en = '0; layer_key_en = '0; layer_x = '0; layer_y = '0;
        layer_w = '0; layer_h = '0; layer_key = '0;
        for (int i = 0; i < NL; i++) begin force_en[i] = 1'b0; force_val[i] = '0; end
        model_reset();

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        expect_val("reset_rgb", 128'({r, g, b}), 128'(0));
        expect_val("reset_flags", 128'({pix_valid_out, hsync_out, vsync_out}), 128'(0));
        expect_val("reset_addr", 128'(rom_addr), 128'(0));
        rst_n = 1'b1;
        idle(LAT + 1);

        // Background sweep, no layers, lose mode
        pix(5, 300, 1'b1, 1'b0, 2);
        pix(400, 300, 1'b1, 1'b0, 2);
        pix(400, 650, 1'b1, 1'b0, 2);
        pix(400, 700, 1'b1, 1'b0, 2);
        expect_val("bg_border", 128'({r, g, b}), 128'(12'hF00));
        idle(1);
        expect_val("bg_lose", 128'({r, g, b}), 128'(12'hC0A));
        idle(1);
        expect_val("bg_grass", 128'({r, g, b}), 128'(12'h9C0));
        idle(1);
        expect_val("bg_ground", 128'({r, g, b}), 128'(12'h960));
        idle(LAT);

        // Single layer 0 hit test and address
        set_layer(0, 1'b1, 100, 200, 71, 54, 0, 1'b0);
        pix(0, 0, 1'b0, 1'b1, 0);
        pix(105, 203, 1'b1, 1'b0, 0);
        expect_val("addr_105_203", 128'(rom_addr[AW-1:0]), 128'(218));
        pix(99, 203, 1'b1, 1'b0, 0);
        expect_val("addr_x99_miss", 128'(rom_addr[AW-1:0]), 128'(0));
        pix(100, 203, 1'b1, 1'b0, 0);
        expect_val("addr_x100_hit", 128'(rom_addr[AW-1:0]), 128'(213));
        pix(170, 203, 1'b1, 1'b0, 0);
        expect_val("addr_x170_hit", 128'(rom_addr[AW-1:0]), 128'(283));
        expect_val("rgb_rom_word", 128'({r, g, b}), 128'(12'h0AD));
        pix(171, 203, 1'b1, 1'b0, 0);
        expect_val("addr_x171_miss", 128'(rom_addr[AW-1:0]), 128'(0));
        expect_val("rgb_x99_bg", 128'({r, g, b}), 128'(12'h0AE));
        idle(LAT);

        // Overlap of layers 2 and 5 with colour key
        set_layer(0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        set_layer(2, 1'b1, 250, 250, 100, 100, 0, 1'b0);
        set_layer(5, 1'b1, 290, 290, 20, 20, 12'h000, 1'b1);
        force_en[2] = 1'b1; force_val[2] = 12'hABC;
        force_en[5] = 1'b1; force_val[5] = 12'h000;
        pix(0, 0, 1'b0, 1'b1, 0);
        pix(300, 300, 1'b1, 1'b0, 0);
        idle(LAT - 1);
        expect_val("overlap_keyed", 128'({r, g, b}), 128'(12'hABC));
        idle(LAT);
        force_val[5] = 12'h0F0;
        pix(300, 300, 1'b1, 1'b0, 0);
        idle(LAT - 1);
        expect_val("overlap_top", 128'({r, g, b}), 128'(12'h0F0));
        idle(LAT);

        // Frame-synchronous parameter update
        force_en[2] = 1'b0; force_en[5] = 1'b0;
        layer_en[5] = 1'b0;
        pix(0, 0, 1'b0, 1'b1, 1);
        layer_x[2*CW +: CW] = CW'(310);
        pix(300, 300, 1'b1, 1'b0, 1);
        pix(300, 300, 1'b1, 1'b1, 1);
        idle(LAT - 2);
        expect_val("sync_old_x", 128'({r, g, b}), 128'(12'h2AB));
        idle(1);
        expect_val("sync_new_x", 128'({r, g, b}), 128'(12'hCF0));
        idle(LAT);

        // Coordinate edges: no wrap past 2^COORD_W, zero width/height never hits
        set_layer(3, 1'b1, 2040, 0, 20, 2000, 0, 1'b0);
        set_layer(4, 1'b1, 0, 0, 0, 500, 0, 1'b0);
        set_layer(6, 1'b1, 0, 0, 500, 0, 0, 1'b0);
        pix(0, 0, 1'b0, 1'b1, 0);
        pix(3, 100, 1'b1, 1'b0, 0);
        expect_val("wrap_miss", 128'(rom_addr[3*AW +: AW]), 128'(0));
        pix(2045, 100, 1'b1, 1'b0, 0);
        expect_val("edge_hit", 128'(rom_addr[3*AW +: AW]), 128'(2005));
        pix(5, 5, 1'b1, 1'b0, 0);
        expect_val("w0_miss", 128'(rom_addr[4*AW +: AW]), 128'(0));
        expect_val("h0_miss", 128'(rom_addr[6*AW +: AW]), 128'(0));
        idle(LAT);

        // Randomized frames with mid-frame parameter changes and ticks on active pixels
        for (int f = 0; f < 12; f++) begin
            random_layers();
            for (int k = 0; k < 64; k++) begin
                int x, y;
                if ($urandom_range(0, 7) == 0) begin
                    x = int'($urandom_range(0, 2047)); y = int'($urandom_range(0, 800));
                end else begin
                    x = int'($urandom_range(0, 450)); y = int'($urandom_range(0, 450));
                end
                pix(x, y, 1'($urandom_range(0, 4) != 0), 1'(k == 20 || $urandom_range(0, 40) == 0),
                    int'($urandom_range(0, 3)));
                if (k == 40) random_layers();
            end
        end

        // Asynchronous reset in the middle of active drawing
        set_layer(1, 1'b1, 50, 50, 200, 200, 0, 1'b0);
        pix(0, 0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 6; k++) pix(60 + k, 60, 1'b1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        expect_val("async_rgb", 128'({r, g, b}), 128'(0));
        expect_val("async_flags", 128'({pix_valid_out, hsync_out, vsync_out}), 128'(0));
        expect_val("async_addr", 128'(rom_addr), 128'(0));
        model_reset();
        pix_valid_in = 1'b0; frame_tick = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        m = 0;
        for (int k = 0; k < 6; k++) pix(60 + k, 60, 1'b1, 1'b0, 0);
        idle(LAT - 2);
        expect_val("post_reset_bg", 128'({r, g, b}), 128'(12'h0AE));
        pix(0, 0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 40; k++)
            pix(int'($urandom_range(0, 300)), int'($urandom_range(0, 300)), 1'b1, 1'b0,
                int'($urandom_range(0, 3)));
        idle(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
